ic_bvslt_bvashr_enum: RTL and testbench
=======================================

IC_BVSLT_BVASHR_ENUM -- requirements
Module: ic_bvslt_bvashr_enum

Interface
REQ-001 Parameter W, default 4: operand width in bits; legal range 2..16.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port rst  input  1: reset, synchronous, active-high.
REQ-004 Port start  input  1: request a new enumeration; sampled only in IDLE.
REQ-005 Port s  input  W: shift amount, unsigned; captured with start.
REQ-006 Port t  input  W: comparison bound, two's complement; captured with start.
REQ-007 Port busy  output  1: high in any state other than IDLE.
REQ-008 Port wit_valid  output  1: wit_x holds a witness.
REQ-009 Port wit_ready  input  1: consumer accepts the witness.
REQ-010 Port wit_x  output  W: candidate x satisfying (x >>a s) <s t.
REQ-011 Port done  output  1: one-cycle pulse at end of enumeration.
REQ-012 Port sat  output  1: at least one witness was emitted; valid from done until the next start.
REQ-013 Port count  output  W+1: number of accepted witnesses; valid from done until the next start.

Function
REQ-014 Predicate P(x) SHALL be (x >>a s) <s t: arithmetic right shift, signed less-than, W-bit x.
REQ-015 Shift SHALL saturate: s >= W gives all-sign-bit fill (0 or all-ones).
REQ-016 States SHALL be IDLE, SCAN, DONE.
REQ-017 IDLE + start: latch s and t, clear count, clear sat, set candidate x=0, go to SCAN.
REQ-018 start SHALL be ignored outside IDLE; s and t changes after capture SHALL have no effect.
REQ-019 In SCAN, wit_valid SHALL equal P(x) combinationally on the registered x and latched s and t; wit_x SHALL equal x.
REQ-020 In SCAN, the candidate SHALL advance when P(x)=0, or when wit_valid and wit_ready are both high; otherwise x, wit_valid and wit_x SHALL hold.
REQ-021 Each wit_valid&wit_ready handshake SHALL increment count by 1; count is W+1 bits and SHALL NOT wrap (maximum 2^W).
REQ-022 Candidates SHALL be visited in ascending unsigned order 0..2^W-1, each exactly once.
REQ-023 When the advance condition holds on x=2^W-1, the state SHALL go to DONE and x SHALL NOT wrap.
REQ-024 DONE SHALL last exactly one cycle with done=1 and sat=(count!=0), then return to IDLE.
REQ-025 A start held high during DONE SHALL NOT be sampled; it is sampled on the following IDLE cycle.
REQ-026 With wit_ready tied high, done SHALL assert 2^W+1 cycles after the start cycle.
REQ-027 wit_valid SHALL be 0 in IDLE and DONE.

Reset
REQ-028 rst SHALL force IDLE, x=0, count=0, sat=0, done=0, wit_valid=0, busy=0 on the next edge.
REQ-029 rst SHALL take priority over start and over any in-flight handshake, including mid-SCAN; a pending witness SHALL be dropped and SHALL NOT be counted.

Configuration
REQ-030 Macro IC_BVSLT_FASTPATH_EN, when defined, SHALL evaluate the invertibility condition IC = (MIN >>a s) <s t in IDLE on start, where MIN = 1 followed by W-1 zeros.
REQ-031 With the macro defined and IC=0, the state SHALL go from IDLE directly to DONE: done one cycle after start, count=0, sat=0, no wit_valid.
REQ-032 With the macro defined and IC=1, behaviour SHALL be as in REQ-017.
REQ-033 With the macro undefined, every start SHALL scan all 2^W candidates.
REQ-034 Witness sequence, count and sat SHALL be identical with and without the macro; only latency differs.

Verification
REQ-035 W=4, s=1, t=0, wit_ready=1 -> witnesses 8..15 in order, count=8, sat=1, done at cycle 17.
REQ-036 W=4, s=0, t=4'b1000 (-8) -> no wit_valid, count=0, sat=0; done at cycle 17 without macro, cycle 1 with macro.
REQ-037 W=4, s=5, t=0 -> saturated shift; witnesses 8..15, count=8.
REQ-038 W=4, s=0, t=2, wit_ready low 3 cycles on x=9 -> wit_x stays 9 and wit_valid stays 1 for 3 cycles; no skip; no double count.
REQ-039 rst pulsed at x=10 during SCAN -> IDLE next cycle, all outputs at reset values; a later start with s=1, t=0 gives count=8.
REQ-040 Random s and t for W=4,6 -> emitted set equals the reference-model set of x with P(x)=1; count matches; both macro settings.

Source files
------------

// File: rtl/ic_bvslt_bvashr_enum.sv
// ---------------------------------------------------------------------------
// ic_bvslt_bvashr_enum
//
// Purpose:
//   Enumerates every W-bit value x, in ascending unsigned order, and offers
//   each one satisfying P(x) = (x >>a s) <s t on a valid/ready witness port.
//   The shift is arithmetic and saturates: any s >= W fills the result with
//   the sign bit. Accepted witnesses are counted. A one-cycle done pulse
//   closes each enumeration and reports whether any witness was accepted.
//
// Optional feature:
//   IC_BVSLT_FASTPATH_EN - when defined, the invertibility condition
//   IC = (MIN >>a s) <s t is evaluated on start, with MIN the most negative
//   W-bit value. If IC is false no x can satisfy P, so the scan is skipped
//   and DONE follows the start cycle directly. Witnesses, count and sat are
//   the same in both builds; only latency differs.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   begin an enumeration (sampled in IDLE only)
//   s          in   [W-1:0] shift amount, unsigned, captured with start
//   t          in   [W-1:0] signed comparison bound, captured with start
//   busy       out  high whenever not IDLE
//   wit_valid  out  wit_x carries a witness
//   wit_ready  in   consumer accepts the witness
//   wit_x      out  [W-1:0] current candidate
//   done       out  one-cycle end-of-enumeration pulse
//   sat        out  at least one witness was accepted
//   count      out  [W:0] number of accepted witnesses
// ---------------------------------------------------------------------------
module ic_bvslt_bvashr_enum #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         busy,
  output logic         wit_valid,
  input  logic         wit_ready,
  output logic [W-1:0] wit_x,
  output logic         done,
  output logic         sat,
  output logic [W:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Largest shift that still has a distinct effect; anything above it
  // produces the same all-sign-bit result.
  localparam int           SH_MAX_I = W - 1;
  localparam logic [W-1:0] SH_MAX   = SH_MAX_I[W-1:0];
  localparam logic [W-1:0] X_LAST   = '1;
  localparam logic [W-1:0] X_ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   CNT_ONE  = {{W{1'b0}}, 1'b1};
`ifdef IC_BVSLT_FASTPATH_EN
  localparam logic [W-1:0] X_MIN    = {1'b1, {(W-1){1'b0}}};
`endif

  state_e       state_q, state_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] t_q, t_d;
  logic [W:0]   count_q, count_d;
  logic         sat_q, sat_d;
  logic         p_cur;
  logic         handshake;
  logic         advance;

  // Saturating arithmetic right shift followed by a signed compare.
  // Clamping the amount to W-1 keeps the shifter small and yields the
  // same sign-filled result as any larger shift.
  function automatic logic pred(input logic [W-1:0] xv,
                                input logic [W-1:0] sv,
                                input logic [W-1:0] tv);
    logic [W-1:0]        shamt;
    logic signed [W-1:0] shifted;
    shamt   = (sv > SH_MAX) ? SH_MAX : sv;
    shifted = $signed(xv) >>> shamt;
    return shifted < $signed(tv);
  endfunction

  assign p_cur     = pred(x_q, s_q, t_q);
  assign wit_valid = (state_q == SCAN) && p_cur;
  assign handshake = wit_valid && wit_ready;
  // A non-witness is skipped at once; a witness waits for the consumer.
  assign advance   = (state_q == SCAN) && (!p_cur || wit_ready);

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign wit_x = x_q;
  assign sat   = sat_q;
  assign count = count_q;

  // Next-state and datapath. Every candidate is visited exactly once, so
  // count can never exceed 2^W and needs no wrap protection.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    s_d     = s_q;
    t_d     = t_q;
    count_d = count_q;
    sat_d   = sat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = s;
          t_d     = t;
          x_d     = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = SCAN;
`ifdef IC_BVSLT_FASTPATH_EN
          // MIN >>a s is the smallest value the shift can produce; if even
          // that is not below t, the scan cannot find a witness.
          if (!pred(X_MIN, s, t)) begin
            state_d = DONE;
          end
`endif
        end
      end

      SCAN: begin
        if (handshake) begin
          count_d = count_q + CNT_ONE;
        end
        if (advance) begin
          if (x_q == X_LAST) begin
            // x stays at the last candidate rather than wrapping to 0.
            state_d = DONE;
            sat_d   = (count_d != '0);
          end else begin
            x_d = x_q + X_ONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over everything, including a handshake on the same edge, so
  // a witness pending at reset is dropped without being counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      s_q     <= s_d;
      t_q     <= t_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_ic_bvslt_bvashr_enum.sv
// ---------------------------------------------------------------------------
// tb_ic_bvslt_bvashr_enum
//
// Two instances (W=4 and W=6) share clock and reset. For every enumeration
// the expected witness list and final count come from an integer reference
// model of P(x) and are queued; monitors on the falling edge pop and compare
// on every handshake and on every done pulse. Works with and without
// IC_BVSLT_FASTPATH_EN (only the expected latency changes).
// ---------------------------------------------------------------------------
module tb_ic_bvslt_bvashr_enum;

  logic clk;
  logic rst;

  logic       start4, ready4, busy4, valid4, done4, sat4;
  logic [3:0] s4, t4, x4;
  logic [4:0] count4;

  logic       start6, ready6, busy6, valid6, done6, sat6;
  logic [5:0] s6, t6, x6;
  logic [6:0] count6;

  int checks = 0;
  int errors = 0;

  int expWit4[$];
  int expCnt4[$];
  int expWit6[$];
  int expCnt6[$];
  int c4, c6;

  ic_bvslt_bvashr_enum #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .s(s4), .t(t4),
    .busy(busy4), .wit_valid(valid4), .wit_ready(ready4), .wit_x(x4),
    .done(done4), .sat(sat4), .count(count4)
  );

  ic_bvslt_bvashr_enum #(.W(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .s(s6), .t(t6),
    .busy(busy6), .wit_valid(valid6), .wit_ready(ready6), .wit_x(x6),
    .done(done6), .sat(sat6), .count(count6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  // P(x) from integer arithmetic: signed reinterpretation, arithmetic shift
  // as floor division by 2^s (or pure sign for s >= w), signed compare.
  function automatic bit refPred(input int w, input int x, input int s, input int t);
    int xs, ts, q, d;
    xs = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    ts = (t >= (1 << (w - 1))) ? t - (1 << w) : t;
    if (s >= w) begin
      q = (xs < 0) ? -1 : 0;
    end else begin
      d = 1 << s;
      q = xs / d;
      if ((xs % d != 0) && (xs < 0)) q = q - 1;
    end
    return q < ts;
  endfunction

  function automatic int expLatency(input int w, input int s, input int t);
`ifdef IC_BVSLT_FASTPATH_EN
    if (!refPred(w, 1 << (w - 1), s, t)) return 1;
`endif
    return (1 << w) + 1;
  endfunction

  task automatic pushExpect4(input int sv, input int tv, output int n);
    n = 0;
    for (int x = 0; x < 16; x++) begin
      if (refPred(4, x, sv, tv)) begin
        expWit4.push_back(x);
        n++;
      end
    end
    expCnt4.push_back(n);
  endtask

  task automatic pushExpect6(input int sv, input int tv, output int n);
    n = 0;
    for (int x = 0; x < 64; x++) begin
      if (refPred(6, x, sv, tv)) begin
        expWit6.push_back(x);
        n++;
      end
    end
    expCnt6.push_back(n);
  endtask

  // Scoreboard monitor, W=4
  always @(negedge clk) begin
    if (!rst) begin
      if (valid4 && ready4) begin
        if (expWit4.size() == 0) begin
          reportFail($sformatf("w4 unexpected witness x=%0d", x4));
        end else begin
          checkOutput("w4 witness", int'(x4), expWit4.pop_front());
        end
      end
      if (!busy4 || done4) begin
        checkOutput("w4 wit_valid outside SCAN", int'(valid4), 0);
      end
      if (done4) begin
        checkOutput("w4 witnesses left at done", expWit4.size(), 0);
        expWit4.delete();
        if (expCnt4.size() == 0) begin
          reportFail("w4 unexpected done");
        end else begin
          c4 = expCnt4.pop_front();
          checkOutput("w4 count at done", int'(count4), c4);
          checkOutput("w4 sat at done", int'(sat4), int'(c4 != 0));
        end
      end
    end
  end

  // Scoreboard monitor, W=6
  always @(negedge clk) begin
    if (!rst) begin
      if (valid6 && ready6) begin
        if (expWit6.size() == 0) begin
          reportFail($sformatf("w6 unexpected witness x=%0d", x6));
        end else begin
          checkOutput("w6 witness", int'(x6), expWit6.pop_front());
        end
      end
      if (!busy6 || done6) begin
        checkOutput("w6 wit_valid outside SCAN", int'(valid6), 0);
      end
      if (done6) begin
        checkOutput("w6 witnesses left at done", expWit6.size(), 0);
        expWit6.delete();
        if (expCnt6.size() == 0) begin
          reportFail("w6 unexpected done");
        end else begin
          c6 = expCnt6.pop_front();
          checkOutput("w6 count at done", int'(count6), c6);
          checkOutput("w6 sat at done", int'(sat6), int'(c6 != 0));
        end
      end
    end
  end

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expWit4.delete(); expCnt4.delete();
    expWit6.delete(); expCnt6.delete();
  endtask

  // One W=4 enumeration. mode: 0 ready high, 1 random ready, 2 stall 3 cycles
  // on x=9. held: start is raised while the DUT is still in DONE.
  // skipPost: leave the DUT in DONE for a following held start.
  task automatic applyStimulus(input int sv, input int tv, input int mode,
                               input bit held, input bit skipPost);
    int cyc, stall, lat, n;
    bit timedOut;
    s4 = sv[3:0];
    t4 = tv[3:0];
    start4 = 1'b1;
    ready4 = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (held) begin
      @(posedge clk); #1;
      checkOutput("w4 start ignored in DONE busy", int'(busy4), 0);
      checkOutput("w4 done is one cycle", int'(done4), 0);
    end
    pushExpect4(sv, tv, n);
    lat = expLatency(4, sv, tv);
    cyc = 0;
    stall = 0;
    timedOut = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (done4) break;
      if (cyc > 200) begin
        reportFail("w4 done timeout");
        timedOut = 1'b1;
        break;
      end
      start4 = 1'($urandom_range(0, 1));
      s4 = 4'($urandom_range(0, 15));
      t4 = 4'($urandom_range(0, 15));
      if (mode == 0) begin
        ready4 = 1'b1;
      end else if (mode == 1) begin
        ready4 = 1'($urandom_range(0, 1));
      end else if (stall == 0) begin
        if (valid4 && x4 == 4'd9) begin
          ready4 = 1'b0;
          stall = 1;
        end else begin
          ready4 = 1'b1;
        end
      end else if (stall <= 3) begin
        checkOutput("w4 stalled wit_x", int'(x4), 9);
        checkOutput("w4 stalled wit_valid", int'(valid4), 1);
        if (stall == 3) ready4 = 1'b1;
        stall++;
      end else begin
        ready4 = 1'b1;
      end
    end
    start4 = 1'b0;
    if (timedOut) begin
      pulseReset();
    end else begin
      if (mode == 0 || lat == 1) checkOutput("w4 done latency", cyc, lat);
      if (!skipPost) begin
        @(posedge clk); #1;
        checkOutput("w4 idle after done busy", int'(busy4), 0);
        checkOutput("w4 idle after done done", int'(done4), 0);
        checkOutput("w4 count holds", int'(count4), n);
        checkOutput("w4 sat holds", int'(sat4), int'(n != 0));
      end
    end
  endtask

  // One W=6 enumeration with random ready; the monitor checks the result.
  task automatic applyStimulus6(input int sv, input int tv);
    int cyc, lat, n;
    s6 = sv[5:0];
    t6 = tv[5:0];
    start6 = 1'b1;
    ready6 = 1'($urandom_range(0, 1));
    pushExpect6(sv, tv, n);
    lat = expLatency(6, sv, tv);
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      start6 = 1'b0;
      if (done6) break;
      if (cyc > 600) begin
        reportFail("w6 done timeout");
        pulseReset();
        break;
      end
      s6 = 6'($urandom_range(0, 63));
      t6 = 6'($urandom_range(0, 63));
      ready6 = 1'($urandom_range(0, 1));
    end
    if (done6 && lat == 1) checkOutput("w6 fast done latency", cyc, lat);
    if (done6) begin
      @(posedge clk); #1;
      checkOutput("w6 idle after done", int'(busy6), 0);
    end
  endtask

  // Reset in the middle of a scan while a witness (x=10) is being accepted.
  task automatic resetMidScan();
    int n, cyc;
    s4 = 4'd1; t4 = 4'd0; ready4 = 1'b1; start4 = 1'b1;
    pushExpect4(1, 0, n);
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      cyc++;
      if (busy4 && x4 == 4'd10) break;
      if (cyc > 40) begin
        reportFail("w4 never reached x=10");
        break;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expWit4.delete();
    expCnt4.delete();
    checkOutput("w4 mid-scan reset busy", int'(busy4), 0);
    checkOutput("w4 mid-scan reset done", int'(done4), 0);
    checkOutput("w4 mid-scan reset wit_valid", int'(valid4), 0);
    checkOutput("w4 mid-scan reset count", int'(count4), 0);
    checkOutput("w4 mid-scan reset sat", int'(sat4), 0);
    checkOutput("w4 mid-scan reset x", int'(x4), 0);
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; ready4 = 1'b0; s4 = '0; t4 = '0;
    start6 = 1'b0; ready6 = 1'b0; s6 = '0; t6 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy4", int'(busy4), 0);
    checkOutput("reset done4", int'(done4), 0);
    checkOutput("reset valid4", int'(valid4), 0);
    checkOutput("reset count4", int'(count4), 0);
    checkOutput("reset sat4", int'(sat4), 0);
    checkOutput("reset x4", int'(x4), 0);
    checkOutput("reset busy6", int'(busy6), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 8, 0, 1'b0, 1'b0);
    applyStimulus(5, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 2, 2, 1'b0, 1'b1);
    applyStimulus(1, 0, 1, 1'b1, 1'b0);
    resetMidScan();
    applyStimulus(1, 0, 0, 1'b0, 1'b0);
    applyStimulus(15, 7, 0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 1'b0, 1'b0);
    applyStimulus(3, 15, 1, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 1), 1'b0, 1'b0);
    end

    applyStimulus6(2, 0);
    applyStimulus6(0, 32);
    applyStimulus6(63, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus6($urandom_range(0, 63), $urandom_range(0, 63));
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("w4 queues drained", expWit4.size() + expCnt4.size(), 0);
    checkOutput("w6 queues drained", expWit6.size() + expCnt6.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
